tawas_regfile: RTL and testbench

- Architectural register file and flags register for the Tawas core. Directly downstream of tawas_au.
- Consumes the AU writeback/flags bus, the immediate-load path and the load/store writeback path.
- Presents all eight 32-bit registers as a flat 256-bit regdata bus back to the AU.
- Tracks outstanding loads in a busy scoreboard and flags writeback hazards.

---
 rtl/tawas_pkg.sv | 26 ++
 rtl/tawas_rf_scoreboard.sv | 67 ++++++
 rtl/tawas_regfile.sv | 104 ++++++++++
 tb/tb_tawas_regfile.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tawas_pkg.sv
// Shared widths and writeback-source encoding for the Tawas core.
// Register file bypass is selected by the TAWAS_RF_BYPASS_EN macro in the users of this package.
package tawas_pkg;

  localparam int TAWAS_REG_IDX_W = 3;
  localparam int TAWAS_NUM_REGS  = 8;
  localparam int TAWAS_DATA_W    = 32;
  localparam int TAWAS_FLAGS_W   = 8;

  // Ordered by priority: a higher encoding wins a same-register collision.
  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_IMM  = 2'd1,
    WB_SRC_AU   = 2'd2,
    WB_SRC_LS   = 2'd3
  } wb_src_e;

  function automatic wb_src_e wb_select(input logic ls_hit, input logic au_hit,
                                        input logic imm_hit);
    if (ls_hit)       return WB_SRC_LS;
    else if (au_hit)  return WB_SRC_AU;
    else if (imm_hit) return WB_SRC_IMM;
    else              return WB_SRC_NONE;
  endfunction

endpackage

// File: rtl/tawas_rf_scoreboard.sv
// Busy scoreboard for outstanding loads and the registered writeback-hazard pulse.
// With TAWAS_RF_BYPASS_EN defined, busy also shows same-cycle clears.
module tawas_rf_scoreboard
  import tawas_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pend_en,
  input  logic [TAWAS_REG_IDX_W-1:0] pend_reg,
  input  logic                       clr_en,
  input  logic [TAWAS_REG_IDX_W-1:0] clr_reg,
  input  logic                       au_wr_en,
  input  logic [TAWAS_REG_IDX_W-1:0] au_wr_reg,
  input  logic                       imm_wr_en,
  input  logic [TAWAS_REG_IDX_W-1:0] imm_wr_reg,
  output logic [TAWAS_NUM_REGS-1:0]  busy,
  output logic                       hazard
);

  logic [TAWAS_NUM_REGS-1:0] busy_reg;
  logic [TAWAS_NUM_REGS-1:0] busy_next;
  logic [TAWAS_NUM_REGS-1:0] set_vec;
  logic [TAWAS_NUM_REGS-1:0] clr_vec;
  logic                      hazard_reg;
  logic                      hazard_next;

  genvar gi;
  generate
    for (gi = 0; gi < TAWAS_NUM_REGS; gi++) begin : g_vec
      assign set_vec[gi] = pend_en && (pend_reg == TAWAS_REG_IDX_W'(gi));
      assign clr_vec[gi] = clr_en  && (clr_reg  == TAWAS_REG_IDX_W'(gi));
    end
  endgenerate

  // Set after clear so a back-to-back load to the same register stays busy.
  assign busy_next = (busy_reg & ~clr_vec) | set_vec;

  // Only committed AU/imm writes are judged; writes that lost arbitration are dropped silently.
  always_comb begin
    hazard_next = 1'b0;
    if (au_wr_en && busy_reg[au_wr_reg])
      hazard_next = 1'b1;
    if (imm_wr_en && busy_reg[imm_wr_reg])
      hazard_next = 1'b1;
    if (clr_en && !busy_reg[clr_reg])
      hazard_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg   <= '0;
      hazard_reg <= 1'b0;
    end else begin
      busy_reg   <= busy_next;
      hazard_reg <= hazard_next;
    end
  end

`ifdef TAWAS_RF_BYPASS_EN
  assign busy = busy_reg & ~clr_vec;
`else
  assign busy = busy_reg;
`endif

  assign hazard = hazard_reg;

endmodule

// File: rtl/tawas_regfile.sv
// Tawas architectural register file, flags register and load scoreboard wrapper.
// Define TAWAS_RF_BYPASS_EN to forward same-cycle writes to regdata/flags/reg_busy.
module tawas_regfile
  import tawas_pkg::*;
#(
  parameter logic [TAWAS_DATA_W-1:0]  REG_RESET   = 32'h0000_0000,
  parameter logic [TAWAS_FLAGS_W-1:0] FLAGS_RESET = 8'h00
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   rf_imm_en,
  input  logic [TAWAS_REG_IDX_W-1:0]             rf_imm_reg,
  input  logic [TAWAS_DATA_W-1:0]                rf_imm,
  input  logic                                   wb_au_en,
  input  logic [TAWAS_REG_IDX_W-1:0]             wb_au_reg,
  input  logic [TAWAS_DATA_W-1:0]                wb_au_data,
  input  logic                                   wb_au_flags_en,
  input  logic [TAWAS_FLAGS_W-1:0]               wb_au_flags,
  input  logic                                   ls_pend_en,
  input  logic [TAWAS_REG_IDX_W-1:0]             ls_pend_reg,
  input  logic                                   wb_ls_en,
  input  logic [TAWAS_REG_IDX_W-1:0]             wb_ls_reg,
  input  logic [TAWAS_DATA_W-1:0]                wb_ls_data,
  output logic [TAWAS_NUM_REGS*TAWAS_DATA_W-1:0] regdata,
  output logic [TAWAS_FLAGS_W-1:0]               flags,
  output logic [TAWAS_NUM_REGS-1:0]              reg_busy,
  output logic                                   wb_hazard
);

  logic                     au_commit;
  logic                     imm_commit;
  logic [TAWAS_FLAGS_W-1:0] flags_reg;

  // A write commits only if no higher-priority source targets the same register.
  assign au_commit  = wb_au_en && !(wb_ls_en && (wb_ls_reg == wb_au_reg));
  assign imm_commit = rf_imm_en
                      && !(wb_ls_en && (wb_ls_reg == rf_imm_reg))
                      && !(wb_au_en && (wb_au_reg == rf_imm_reg));

  genvar gi;
  generate
    for (gi = 0; gi < TAWAS_NUM_REGS; gi++) begin : g_reg
      logic [TAWAS_DATA_W-1:0] data_reg;
      logic [TAWAS_DATA_W-1:0] data_next;
      wb_src_e                 src;

      assign src = wb_select(wb_ls_en  && (wb_ls_reg  == TAWAS_REG_IDX_W'(gi)),
                             wb_au_en  && (wb_au_reg  == TAWAS_REG_IDX_W'(gi)),
                             rf_imm_en && (rf_imm_reg == TAWAS_REG_IDX_W'(gi)));

      always_comb begin
        data_next = data_reg;
        case (src)
          WB_SRC_LS:  data_next = wb_ls_data;
          WB_SRC_AU:  data_next = wb_au_data;
          WB_SRC_IMM: data_next = rf_imm;
          default:    data_next = data_reg;
        endcase
      end

      always_ff @(posedge clk) begin
        if (rst)
          data_reg <= REG_RESET;
        else
          data_reg <= data_next;
      end

`ifdef TAWAS_RF_BYPASS_EN
      assign regdata[gi*TAWAS_DATA_W +: TAWAS_DATA_W] = data_next;
`else
      assign regdata[gi*TAWAS_DATA_W +: TAWAS_DATA_W] = data_reg;
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)
      flags_reg <= FLAGS_RESET;
    else if (wb_au_flags_en)
      flags_reg <= wb_au_flags;
  end

`ifdef TAWAS_RF_BYPASS_EN
  assign flags = wb_au_flags_en ? wb_au_flags : flags_reg;
`else
  assign flags = flags_reg;
`endif

  tawas_rf_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .pend_en    (ls_pend_en),
    .pend_reg   (ls_pend_reg),
    .clr_en     (wb_ls_en),
    .clr_reg    (wb_ls_reg),
    .au_wr_en   (au_commit),
    .au_wr_reg  (wb_au_reg),
    .imm_wr_en  (imm_commit),
    .imm_wr_reg (rf_imm_reg),
    .busy       (reg_busy),
    .hazard     (wb_hazard)
  );

endmodule

// File: tb/tb_tawas_regfile.sv
// Directed self-checking bench for tawas_regfile in its default (registered-output) build.
module tb_tawas_regfile;
  import tawas_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         rf_imm_en;
  logic [2:0]   rf_imm_reg;
  logic [31:0]  rf_imm;
  logic         wb_au_en;
  logic [2:0]   wb_au_reg;
  logic [31:0]  wb_au_data;
  logic         wb_au_flags_en;
  logic [7:0]   wb_au_flags;
  logic         ls_pend_en;
  logic [2:0]   ls_pend_reg;
  logic         wb_ls_en;
  logic [2:0]   wb_ls_reg;
  logic [31:0]  wb_ls_data;
  logic [255:0] regdata;
  logic [7:0]   flags;
  logic [7:0]   reg_busy;
  logic         wb_hazard;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [8];

  always #5 clk = ~clk;

  tawas_regfile dut (
    .clk            (clk),
    .rst            (rst),
    .rf_imm_en      (rf_imm_en),
    .rf_imm_reg     (rf_imm_reg),
    .rf_imm         (rf_imm),
    .wb_au_en       (wb_au_en),
    .wb_au_reg      (wb_au_reg),
    .wb_au_data     (wb_au_data),
    .wb_au_flags_en (wb_au_flags_en),
    .wb_au_flags    (wb_au_flags),
    .ls_pend_en     (ls_pend_en),
    .ls_pend_reg    (ls_pend_reg),
    .wb_ls_en       (wb_ls_en),
    .wb_ls_reg      (wb_ls_reg),
    .wb_ls_data     (wb_ls_data),
    .regdata        (regdata),
    .flags          (flags),
    .reg_busy       (reg_busy),
    .wb_hazard      (wb_hazard)
  );

  function automatic logic [255:0] pack_model();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = model[i];
    return v;
  endfunction

  task automatic idle();
    rst = 1'b0;
    rf_imm_en = 1'b0; rf_imm_reg = '0; rf_imm = '0;
    wb_au_en = 1'b0; wb_au_reg = '0; wb_au_data = '0;
    wb_au_flags_en = 1'b0; wb_au_flags = '0;
    ls_pend_en = 1'b0; ls_pend_reg = '0;
    wb_ls_en = 1'b0; wb_ls_reg = '0; wb_ls_data = '0;
  endtask

  // Commit whatever is driven, then return all strobes to idle; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    checks++;
    if (regdata !== 256'h0) begin
      errors++; $display("FAIL reset_regdata got %h exp %h", regdata, 256'h0);
    end
    checks++;
    if (flags !== 8'h00) begin errors++; $display("FAIL reset_flags got %h exp 00", flags); end
    checks++;
    if (reg_busy !== 8'h00) begin errors++; $display("FAIL reset_busy got %h exp 00", reg_busy); end
    checks++;
    if (wb_hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got %b exp 0", wb_hazard); end
    $display("reset: regdata=%h flags=%h busy=%h", regdata, flags, reg_busy);
  endtask

  task automatic test_au_write();
    wb_au_en = 1'b1; wb_au_reg = 3'd3; wb_au_data = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (regdata[127:96] !== 32'h0) begin
      errors++; $display("FAIL au_latency got %h exp 00000000", regdata[127:96]);
    end
    tick();
    model[3] = 32'hDEAD_BEEF;
    checks++;
    if (regdata[127:96] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL au_write_r3 got %h exp deadbeef", regdata[127:96]);
    end
    checks++;
    if (wb_hazard !== 1'b0) begin errors++; $display("FAIL au_write_hazard got %b exp 0", wb_hazard); end
    $display("au write r3: r3=%h", regdata[127:96]);
  endtask

  task automatic test_independent();
    rf_imm_en = 1'b1; rf_imm_reg = 3'd0; rf_imm = 32'h0000_0011;
    wb_au_en = 1'b1; wb_au_reg = 3'd1; wb_au_data = 32'h0000_0022;
    wb_ls_en = 1'b1; wb_ls_reg = 3'd7; wb_ls_data = 32'h0000_0033;
    tick();
    model[0] = 32'h11; model[1] = 32'h22; model[7] = 32'h33;
    checks++;
    if (regdata !== pack_model()) begin
      errors++; $display("FAIL independent_regdata got %h exp %h", regdata, pack_model());
    end
    checks++;
    if (wb_hazard !== 1'b1) begin errors++; $display("FAIL independent_ls_idle_hazard got %b exp 1", wb_hazard); end
    $display("independent writes: r0=%h r1=%h r7=%h hazard=%b",
             regdata[31:0], regdata[63:32], regdata[255:224], wb_hazard);
    tick();
  endtask

  task automatic test_priority();
    ls_pend_en = 1'b1; ls_pend_reg = 3'd5;
    tick();
    checks++;
    if (reg_busy !== 8'h20) begin errors++; $display("FAIL prio_pend_busy got %h exp 20", reg_busy); end
    rf_imm_en = 1'b1; rf_imm_reg = 3'd5; rf_imm = 32'd1;
    wb_au_en = 1'b1; wb_au_reg = 3'd5; wb_au_data = 32'd2;
    wb_ls_en = 1'b1; wb_ls_reg = 3'd5; wb_ls_data = 32'd3;
    tick();
    model[5] = 32'd3;
    checks++;
    if (regdata !== pack_model()) begin
      errors++; $display("FAIL prio_ls_wins got r5=%h exp 00000003", regdata[191:160]);
    end
    checks++;
    if (wb_hazard !== 1'b0) begin errors++; $display("FAIL prio_three_hazard got %b exp 0", wb_hazard); end
    checks++;
    if (reg_busy !== 8'h00) begin errors++; $display("FAIL prio_busy_clear got %h exp 00", reg_busy); end
    rf_imm_en = 1'b1; rf_imm_reg = 3'd5; rf_imm = 32'd1;
    wb_au_en = 1'b1; wb_au_reg = 3'd5; wb_au_data = 32'd2;
    tick();
    model[5] = 32'd2;
    checks++;
    if (regdata !== pack_model()) begin
      errors++; $display("FAIL prio_au_wins got r5=%h exp 00000002", regdata[191:160]);
    end
    checks++;
    if (wb_hazard !== 1'b0) begin errors++; $display("FAIL prio_two_hazard got %b exp 0", wb_hazard); end
    $display("priority: r5=%h hazard=%b", regdata[191:160], wb_hazard);
  endtask

  task automatic test_busy_hazard();
    ls_pend_en = 1'b1; ls_pend_reg = 3'd2;
    tick();
    wb_au_en = 1'b1; wb_au_reg = 3'd2; wb_au_data = 32'd7;
    tick();
    model[2] = 32'd7;
    checks++;
    if (regdata[95:64] !== 32'd7) begin errors++; $display("FAIL busy_au_r2 got %h exp 00000007", regdata[95:64]); end
    checks++;
    if (wb_hazard !== 1'b1) begin errors++; $display("FAIL busy_au_hazard got %b exp 1", wb_hazard); end
    checks++;
    if (reg_busy !== 8'h04) begin errors++; $display("FAIL busy_au_still_busy got %h exp 04", reg_busy); end
    tick();
    checks++;
    if (wb_hazard !== 1'b0) begin errors++; $display("FAIL busy_hazard_one_cycle got %b exp 0", wb_hazard); end
    wb_ls_en = 1'b1; wb_ls_reg = 3'd2; wb_ls_data = 32'd9;
    tick();
    model[2] = 32'd9;
    checks++;
    if (regdata !== pack_model()) begin errors++; $display("FAIL busy_ls_r2 got %h exp 00000009", regdata[95:64]); end
    checks++;
    if (reg_busy !== 8'h00) begin errors++; $display("FAIL busy_ls_clear got %h exp 00", reg_busy); end
    checks++;
    if (wb_hazard !== 1'b0) begin errors++; $display("FAIL busy_ls_hazard got %b exp 0", wb_hazard); end
    $display("busy hazard: r2=%h busy=%h", regdata[95:64], reg_busy);
  endtask

  task automatic test_set_clear();
    ls_pend_en = 1'b1; ls_pend_reg = 3'd4;
    tick();
    ls_pend_en = 1'b1; ls_pend_reg = 3'd4;
    wb_ls_en = 1'b1; wb_ls_reg = 3'd4; wb_ls_data = 32'h44;
    tick();
    model[4] = 32'h44;
    checks++;
    if (reg_busy !== 8'h10) begin errors++; $display("FAIL setclr_busy got %h exp 10", reg_busy); end
    checks++;
    if (wb_hazard !== 1'b0) begin errors++; $display("FAIL setclr_hazard got %b exp 0", wb_hazard); end
    wb_ls_en = 1'b1; wb_ls_reg = 3'd4; wb_ls_data = 32'h45;
    tick();
    model[4] = 32'h45;
    checks++;
    if (reg_busy !== 8'h00) begin errors++; $display("FAIL setclr_drain got %h exp 00", reg_busy); end
    wb_ls_en = 1'b1; wb_ls_reg = 3'd6; wb_ls_data = 32'h66;
    tick();
    model[6] = 32'h66;
    checks++;
    if (wb_hazard !== 1'b1) begin errors++; $display("FAIL ls_idle_hazard got %b exp 1", wb_hazard); end
    checks++;
    if (regdata !== pack_model()) begin errors++; $display("FAIL ls_idle_write got %h exp %h", regdata, pack_model()); end
    tick();
    checks++;
    if (wb_hazard !== 1'b0) begin errors++; $display("FAIL ls_idle_hazard_drop got %b exp 0", wb_hazard); end
    $display("set/clear: r4=%h r6=%h busy=%h", regdata[159:128], regdata[223:192], reg_busy);
  endtask

  task automatic test_flags();
    wb_au_flags_en = 1'b1; wb_au_flags = 8'hA5;
    tick();
    checks++;
    if (flags !== 8'hA5) begin errors++; $display("FAIL flags_load got %h exp a5", flags); end
    checks++;
    if (regdata !== pack_model()) begin errors++; $display("FAIL flags_regs_kept got %h exp %h", regdata, pack_model()); end
    $display("flags: flags=%h", flags);
  endtask

  task automatic test_reset_override();
    ls_pend_en = 1'b1; ls_pend_reg = 3'd3;
    tick();
    rst = 1'b1;
    wb_au_en = 1'b1; wb_au_reg = 3'd1; wb_au_data = 32'h1234_5678;
    wb_au_flags_en = 1'b1; wb_au_flags = 8'h3C;
    tick();
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    checks++;
    if (regdata[63:32] !== 32'h0) begin errors++; $display("FAIL rst_override_r1 got %h exp 00000000", regdata[63:32]); end
    checks++;
    if (regdata !== pack_model()) begin errors++; $display("FAIL rst_override_regdata got %h exp 0", regdata); end
    checks++;
    if (flags !== 8'h00) begin errors++; $display("FAIL rst_override_flags got %h exp 00", flags); end
    checks++;
    if (reg_busy !== 8'h00) begin errors++; $display("FAIL rst_forget_busy got %h exp 00", reg_busy); end
    wb_ls_en = 1'b1; wb_ls_reg = 3'd3; wb_ls_data = 32'hCAFE;
    tick();
    model[3] = 32'hCAFE;
    checks++;
    if (regdata !== pack_model()) begin errors++; $display("FAIL rst_late_ls_write got %h exp 0000cafe", regdata[127:96]); end
    checks++;
    if (wb_hazard !== 1'b1) begin errors++; $display("FAIL rst_late_ls_hazard got %b exp 1", wb_hazard); end
    $display("reset override: r1=%h r3=%h flags=%h hazard=%b",
             regdata[63:32], regdata[127:96], flags, wb_hazard);
  endtask

  initial begin
    idle();
    @(negedge clk);
    test_reset();
    test_au_write();
    test_independent();
    test_priority();
    test_busy_hazard();
    test_set_clear();
    test_flags();
    test_reset_override();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
